// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg - shared definitions for the data-memory port arbiter.
//   SIZE_ADDR / HBIT_ADDR : data-path width (48-bit words and addresses)
//   ARB_IDLE / ARB_DATA   : DMA sequencer state encodings
//   MAX_WAIT_DEF          : default starvation limit before a forced MA bubble
//   dma_lat_t             : DMA request fields held from the address cycle
//                           into the data cycle
package mem_port_arb_pkg;

    localparam int SIZE_ADDR = 48;
    localparam int HBIT_ADDR = SIZE_ADDR - 1;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_DATA = 1'b1;

    localparam int MAX_WAIT_DEF = 8;

    typedef struct packed {
        logic                 we;
        logic                 is48;
        logic                 port;
        logic [HBIT_ADDR:0]   wdata;
    } dma_lat_t;

endpackage

// File: rtl/mem_port_arb_starve.sv
// mem_arb_starve_ctr - saturating wait counter for a pending DMA request.
// Once the request has waited MAX_WAIT cycles, a registered one-cycle
// stall pulse is raised so the pipeline opens a bubble for the DMA.
//   clk, rst : clock, synchronous active-high reset
//   wait_en  : request pending in IDLE and not granted this cycle
//   clr      : request granted or withdrawn
//   stall    : one-cycle forced MA bubble
module mem_arb_starve_ctr #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_en,
    input  logic clr,
    output logic stall
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            stall <= 1'b0;
        end else begin
            // Raised on the edge where cnt reaches MAX_WAIT. The stalled cycle
            // always grants (request is held until gnt), which clears cnt, so
            // the pulse cannot repeat.
            stall <= wait_en && (cnt == WAIT_W'(MAX_WAIT - 1));
            if (clr)
                cnt <= '0;
            else if (wait_en && (cnt != WAIT_W'(MAX_WAIT)))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb - sequences the dual-port data memory between the MA (address)
// and MO (data) stages and slots a DMA/debug requester into pipeline bubbles.
//   iw_clk, iw_rst            : clock, synchronous active-high reset
//   iw_ma_req, iw_mo_req      : pipeline stage accesses this cycle
//   ow_mem_mp                 : port used by MO (MA uses the other one)
//   ow_pipe_stall             : forced MA bubble for a starved DMA request
//   iw_dma_*                  : DMA request (held stable until ow_dma_gnt)
//   ow_dma_gnt/port_en/addr/we/wdata/is48 : DMA drive to the owned port
//   iw_mem_rdata              : per-port read data
//   ow_dma_rvalid/rdata       : DMA read return
//   ow_err                    : sticky, MO accessed during a DMA data cycle
// Optional: define AMBER_MEM_ARB_STATS_EN to add ow_stat_grants and
// ow_stat_forced wrapping event counters.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int WAIT_W   = 8
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     iw_ma_req,
    input  logic                     iw_mo_req,
    output logic                     ow_mem_mp,
    output logic                     ow_pipe_stall,
    input  logic                     iw_dma_req,
    input  logic                     iw_dma_we,
    input  logic                     iw_dma_is48,
    input  logic [HBIT_ADDR:0]       iw_dma_addr,
    input  logic [HBIT_ADDR:0]       iw_dma_wdata,
    output logic                     ow_dma_gnt,
    output logic [1:0]               ow_dma_port_en,
    output logic [HBIT_ADDR:0]       ow_dma_addr,
    output logic                     ow_dma_we,
    output logic [HBIT_ADDR:0]       ow_dma_wdata,
    output logic                     ow_dma_is48,
    input  logic [1:0][HBIT_ADDR:0]  iw_mem_rdata,
    output logic                     ow_dma_rvalid,
    output logic [HBIT_ADDR:0]       ow_dma_rdata,
    output logic                     ow_err
`ifdef AMBER_MEM_ARB_STATS_EN
    ,
    output logic [31:0]              ow_stat_grants,
    output logic [15:0]              ow_stat_forced
`endif
);

    logic [0:0] state;
    dma_lat_t   lat;
    logic       go;
    logic       gnt_port;

    // MA always takes ~mp, so a DMA address cycle borrows that port; the
    // next cycle mp has toggled and the same port belongs to MO.
    assign gnt_port = ~ow_mem_mp;
    assign go       = (state == ARB_IDLE) && iw_dma_req && (!iw_ma_req || ow_pipe_stall);

    mem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_starve (
        .clk     (iw_clk),
        .rst     (iw_rst),
        .wait_en ((state == ARB_IDLE) && iw_dma_req && !go),
        .clr     (go || !iw_dma_req),
        .stall   (ow_pipe_stall)
    );

    always_comb begin
        ow_dma_gnt     = go;
        ow_dma_port_en = 2'b00;
        ow_dma_addr    = '0;
        ow_dma_we      = 1'b0;
        ow_dma_wdata   = '0;
        ow_dma_is48    = 1'b0;
        if (go) begin
            ow_dma_port_en[gnt_port] = 1'b1;
            ow_dma_addr              = iw_dma_addr;
            ow_dma_is48              = iw_dma_is48;
        end else if (state == ARB_DATA) begin
            ow_dma_port_en[lat.port] = 1'b1;
            ow_dma_we                = lat.we;
            ow_dma_wdata             = lat.wdata;
            ow_dma_is48              = lat.is48;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            ow_mem_mp     <= 1'b0;
            state         <= ARB_IDLE;
            lat           <= '0;
            ow_dma_rvalid <= 1'b0;
            ow_dma_rdata  <= '0;
            ow_err        <= 1'b0;
        end else begin
            ow_mem_mp     <= ~ow_mem_mp;
            ow_dma_rvalid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (go) begin
                        lat.we    <= iw_dma_we;
                        lat.is48  <= iw_dma_is48;
                        lat.port  <= gnt_port;
                        lat.wdata <= iw_dma_wdata;
                        state     <= ARB_DATA;
                    end
                end
                default: begin
                    // Request is not re-sampled here; the DMA may already
                    // have dropped it after gnt.
                    state <= ARB_IDLE;
                    if (!lat.we) begin
                        ow_dma_rdata  <= iw_mem_rdata[lat.port];
                        ow_dma_rvalid <= 1'b1;
                    end
                    if (iw_mo_req)
                        ow_err <= 1'b1;
                end
            endcase
        end
    end

`ifdef AMBER_MEM_ARB_STATS_EN
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            ow_stat_grants <= '0;
            ow_stat_forced <= '0;
        end else begin
            if (go)
                ow_stat_grants <= ow_stat_grants + 1'b1;
            if (ow_pipe_stall)
                ow_stat_forced <= ow_stat_forced + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Sequences the dual-port data memory shared by the MA (address phase) and MO (data phase) stages.
- Generates the per-cycle port-select (`mp`) that alternates the two ports between MA and MO.
- Inserts a DMA/debug requester into pipeline bubbles and forces a one-cycle MA bubble when the requester starves.
- Sits between the pipeline stages, the DMA master and the memory; the memory top muxes each port to DMA when `ow_dma_port_en[p]` is set.

Parameters:
- MAX_WAIT, 8, cycles a pending DMA request waits in IDLE before a forced MA bubble (range 1..255).
- WAIT_W, 8, width of the starvation counter.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset, synchronous, active-high
- iw_ma_req  in  1  MA drives an address this cycle
- iw_mo_req  in  1  MO accesses data this cycle
- ow_mem_mp  out  1  port MO uses this cycle; MA uses ~ow_mem_mp
- ow_pipe_stall  out  1  MA must hold and issue no access this cycle
- iw_dma_req  in  1  DMA request; addr/we/wdata/is48 held stable until gnt
- iw_dma_we  in  1  1=store
- iw_dma_is48  in  1  1=48-bit access
- iw_dma_addr  in  48  DMA address
- iw_dma_wdata  in  48  DMA store data
- ow_dma_gnt  out  1  one-cycle pulse; this is the address cycle
- ow_dma_port_en  out  2  per-port DMA ownership this cycle
- ow_dma_addr  out  48  address to owned port (address cycle)
- ow_dma_we  out  1  store enable to owned port (data cycle)
- ow_dma_wdata  out  48  store data (data cycle)
- ow_dma_is48  out  1  width to owned port (both cycles)
- iw_mem_rdata  in  48x2  per-port read bus
- ow_dma_rvalid  out  1  read data valid pulse
- ow_dma_rdata  out  48  captured read data, held until next rvalid
- ow_err  out  1  sticky: iw_mo_req seen in DMA DATA cycle

Behaviour:
- Reset (sync): all outputs 0, `mp`=0, state IDLE, wait counter 0, ow_err 0, latched request 0.
- `mp`: toggles every cycle after reset, unconditionally; stalls do not freeze it.
- FSM IDLE: `go` = iw_dma_req & (~iw_ma_req | ow_pipe_stall).
  - On `go`: ow_dma_gnt=1; ow_dma_port_en[~mp]=1; ow_dma_addr=iw_dma_addr; ow_dma_is48 driven; latch we/wdata/is48/port; next state DATA.
- FSM DATA (one cycle): the same port is now MO's, since `mp` toggled.
  - ow_dma_port_en[port]=1; drive we/wdata/is48 from the latch.
  - If read: capture iw_mem_rdata[port] into ow_dma_rdata; ow_dma_rvalid=1 in the following cycle.
  - If iw_mo_req=1: set ow_err. The DMA access still proceeds.
  - Next state IDLE. A new grant is possible in the cycle after DATA.
- Combinational outputs: gnt, port_en, addr, we, wdata and is48 are combinational from state and latches. is48 is 0 outside DMA cycles.
- Starvation counter:
  - In IDLE with iw_dma_req=1 and no grant: increments, saturating at MAX_WAIT.
  - Clears on grant or when iw_dma_req=0.
  - When the counter reaches MAX_WAIT: ow_pipe_stall is registered high for exactly one cycle, in which `go` is guaranteed and the counter clears.
- Simultaneous events:
  - iw_ma_req & iw_dma_req with no stall: MA wins.
  - iw_rst during DATA: access is aborted, no rvalid, state IDLE.
- DMA may drop iw_dma_req after gnt; the request is not re-sampled in DATA.

Optional Feature:
- AMBER_MEM_ARB_STATS_EN defined: adds outputs ow_stat_grants (32) and ow_stat_forced (16).
  - Wrapping counters of grants and forced stalls; both cleared by reset.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header: FSM state encodings (ARB_IDLE, ARB_DATA) and MAX_WAIT default, added alongside the existing size macros.
- Bus widths use the existing HBIT_ADDR/SIZE_ADDR macros.
- One natural sub-module: mem_arb_starve_ctr (saturating counter plus registered one-cycle stall pulse).

Test Plan:
- Reset, then idle 4 cycles -> ow_mem_mp = 0,1,0,1; all other outputs 0.
- iw_ma_req=0, DMA read addr 0x100 while mp=0 -> gnt and port_en=2'b10 with addr 0x100; next cycle port_en=2'b10, MO port=1. Bench returns rdata[1]=0x123456 -> rvalid pulse next cycle with rdata 0x123456.
- DMA 48-bit write, wdata 0xABCDEF012345, iw_ma_req=0 -> DATA cycle drives we=1, is48=1, wdata on the owned port; no rvalid.
- iw_ma_req held 1, DMA req held, MAX_WAIT=8 -> ow_pipe_stall high in exactly one cycle after 8 waiting cycles; gnt in that same cycle; counter then 0.
- iw_mo_req=1 during DATA -> ow_err=1 and stays 1 until reset.
- iw_rst asserted in DATA cycle of a read -> no rvalid; FSM IDLE and mp=0 next cycle.
